// File: rtl/bp_update_arbiter_pkg.sv
// Shared core types for branch-predictor update arbitration.
// Update packet layout and update-source encoding.
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef BRANCH_TYPE
`define BRANCH_TYPE 2
`endif

package bp_update_arbiter_pkg;

  localparam int SIZE_PC   = `SIZE_PC;
  localparam int BR_TYPE_W = `BRANCH_TYPE;

  typedef struct packed {
    logic [SIZE_PC-1:0]   pc;
    logic [SIZE_PC-1:0]   npc;
    logic [BR_TYPE_W-1:0] ctrlType;
    logic                 dir;
    logic [1:0]           counter;
  } bpUpdPkt;

  typedef enum logic {
    BP_UPD_SRC_CMT = 1'b0,
    BP_UPD_SRC_FS2 = 1'b1
  } bpUpdSrc_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Commit-side update queue; ready depends only on the registered count,
// so a full queue refuses a push even in a cycle that also pops.
module bp_upd_fifo
  import bp_update_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push_i,
  input  bpUpdPkt pkt_i,
  input  logic    pop_i,
  output bpUpdPkt pkt_o,
  output logic    empty_o,
  output logic    ready_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  bpUpdPkt       mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready;
  logic          empty;
  logic          doPush;
  logic          doPop;

  always_comb begin
    ready  = cnt_q < CW'(DEPTH);
    empty  = cnt_q == '0;
    doPush = push_i & ready;
    doPop  = pop_i & ~empty;
    wr_d   = doPush ? wr_q + AW'(1) : wr_q;
    rd_d   = doPop ? rd_q + AW'(1) : rd_q;
    cnt_d  = cnt_q + CW'(doPush) - CW'(doPop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wr_q] <= pkt_i;
  end

  assign pkt_o   = mem_q[rd_q];
  assign empty_o = empty;
  assign ready_o = ready;

endmodule

// File: rtl/bp_update_arbiter.sv
// Arbitrates commit-queue and FS2 predictor updates onto one update port.
// Optional BP_UPD_STATS_EN adds FS2-drop and forced-FS2-grant counters.
module bp_update_arbiter
  import bp_update_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 cmtValid_i,
  output logic                 cmtReady_o,
  input  bpUpdPkt              cmtPkt_i,
  input  logic                 fs2Valid_i,
  input  bpUpdPkt              fs2Pkt_i,
  output logic [SIZE_PC-1:0]   updatePC_o,
  output logic [SIZE_PC-1:0]   updateNPC_o,
  output logic [BR_TYPE_W-1:0] updateCtrlType_o,
  output logic                 updateDir_o,
  output logic [1:0]           updateCounter_o,
  output logic                 updateEn_o
`ifdef BP_UPD_STATS_EN
  ,
  output logic [31:0]          statFs2Drop_o,
  output logic [31:0]          statStarveGrant_o
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  bpUpdPkt       fifoPkt;
  bpUpdPkt       grantPkt;
  bpUpdPkt       fs2Pkt_q, fs2Pkt_d;
  bpUpdPkt       out_q, out_d;
  bpUpdSrc_t     src;
  logic          fifoEmpty;
  logic          grant;
  logic          grantCmt;
  logic          grantFs2;
  logic          fs2Load;
  logic          pend_q, pend_d;
  logic          en_q, en_d;
  logic [SW-1:0] starve_q, starve_d;

  bp_upd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (cmtValid_i),
    .pkt_i  (cmtPkt_i),
    .pop_i  (grantCmt),
    .pkt_o  (fifoPkt),
    .empty_o(fifoEmpty),
    .ready_o(cmtReady_o)
  );

  // FS2 wins when the queue is idle or commit has starved it long enough
  always_comb begin
    grantFs2 = pend_q & (fifoEmpty | (starve_q == SMAX));
    grantCmt = ~fifoEmpty & ~grantFs2;
    grant    = grantFs2 | grantCmt;
    src      = grantFs2 ? BP_UPD_SRC_FS2 : BP_UPD_SRC_CMT;
    grantPkt = (src == BP_UPD_SRC_FS2) ? fs2Pkt_q : fifoPkt;
  end

  always_comb begin
    fs2Load  = fs2Valid_i & ~flush_i;
    pend_d   = pend_q;
    fs2Pkt_d = fs2Pkt_q;
    if (grantFs2) pend_d = 1'b0;
    if (fs2Load) begin
      pend_d   = 1'b1;
      fs2Pkt_d = fs2Pkt_i;
    end
    if (flush_i) pend_d = 1'b0;
    starve_d = starve_q;
    if (!pend_q || grantFs2) begin
      starve_d = '0;
    end else if (grantCmt && starve_q != SMAX) begin
      starve_d = starve_q + SW'(1);
    end
    en_d  = grant;
    out_d = grant ? grantPkt : out_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q   <= 1'b0;
      fs2Pkt_q <= '0;
      starve_q <= '0;
      en_q     <= 1'b0;
      out_q    <= '0;
    end else begin
      pend_q   <= pend_d;
      fs2Pkt_q <= fs2Pkt_d;
      starve_q <= starve_d;
      en_q     <= en_d;
      out_q    <= out_d;
    end
  end

  assign updatePC_o       = out_q.pc;
  assign updateNPC_o      = out_q.npc;
  assign updateCtrlType_o = out_q.ctrlType;
  assign updateDir_o      = out_q.dir;
  assign updateCounter_o  = out_q.counter;
  assign updateEn_o       = en_q;

`ifdef BP_UPD_STATS_EN
  logic [31:0] drop_q, drop_d;
  logic [31:0] stvGnt_q, stvGnt_d;

  // an FS2 grant with commit work waiting was forced by starvation
  always_comb begin
    drop_d   = drop_q;
    stvGnt_d = stvGnt_q;
    if (fs2Load && pend_q && !grantFs2) drop_d = drop_q + 32'd1;
    if (grantFs2 && !fifoEmpty) stvGnt_d = stvGnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q   <= '0;
      stvGnt_q <= '0;
    end else begin
      drop_q   <= drop_d;
      stvGnt_q <= stvGnt_d;
    end
  end

  assign statFs2Drop_o     = drop_q;
  assign statStarveGrant_o = stvGnt_q;
`endif

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Scoreboard bench for bp_update_arbiter: directed stimulus pushes
// expected updates; a negedge monitor pops and compares them.
module tb_bp_update_arbiter;
  import bp_update_arbiter_pkg::*;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 flush = 1'b0;
  logic                 cv = 1'b0;
  logic                 fv = 1'b0;
  bpUpdPkt              cp = '0;
  bpUpdPkt              fp = '0;
  logic                 cmtReady;
  logic [SIZE_PC-1:0]   updPC, updNPC;
  logic [BR_TYPE_W-1:0] updType;
  logic                 updDir;
  logic [1:0]           updCnt;
  logic                 updEn;
`ifdef BP_UPD_STATS_EN
  logic [31:0]          statDrop, statStv;
`endif

  exp_t expq[$];
  int   nChk = 0;
  int   nPass = 0;
  int   nUpd = 0;
  int   cyc = 0;

  // expected cmt0,1,2,f3,cmt3..5,f7,cmt6..8,f11,cmt9..11,f12,cmt12
  logic [31:0] pcsB [17] = '{
    32'h400, 32'h404, 32'h408, 32'h80C,
    32'h40C, 32'h410, 32'h414, 32'h81C,
    32'h418, 32'h41C, 32'h420, 32'h82C,
    32'h424, 32'h428, 32'h42C, 32'h830,
    32'h430
  };

  bp_update_arbiter #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush_i         (flush),
    .cmtValid_i      (cv),
    .cmtReady_o      (cmtReady),
    .cmtPkt_i        (cp),
    .fs2Valid_i      (fv),
    .fs2Pkt_i        (fp),
    .updatePC_o      (updPC),
    .updateNPC_o     (updNPC),
    .updateCtrlType_o(updType),
    .updateDir_o     (updDir),
    .updateCounter_o (updCnt),
    .updateEn_o      (updEn)
`ifdef BP_UPD_STATS_EN
    ,
    .statFs2Drop_o    (statDrop),
    .statStarveGrant_o(statStv)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bpUpdPkt mk(input logic [31:0] pc);
    bpUpdPkt p;
    p.pc       = pc;
    p.npc      = pc + 32'h40;
    p.ctrlType = pc[3:2];
    p.dir      = pc[2];
    p.counter  = pc[5:4];
    return p;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && updEn) begin
      exp_t    e;
      bpUpdPkt p;
      nUpd++;
      if (expq.size() == 0) begin
        nChk++;
        $display("FAIL unexpected_upd: got pc %0h at cyc %0d expected none",
                 updPC, cyc);
      end else begin
        e = expq.pop_front();
        p = mk(e.pc);
        chk("upd_pc", updPC, p.pc);
        chk("upd_fields", {updNPC, updType, updDir, updCnt},
            {p.npc, p.ctrlType, p.dir, p.counter});
        chk("upd_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic expect_upd(input logic [31:0] pc, input int c);
    exp_t e;
    e.pc  = pc;
    e.cyc = c;
    expq.push_back(e);
  endtask

  task automatic drive(input logic cvv, input logic [31:0] cpc,
                       input logic fvv, input logic [31:0] fpc,
                       input logic fl);
    cv    = cvv;
    cp    = mk(cpc);
    fv    = fvv;
    fp    = mk(fpc);
    flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cv    = 1'b0;
    fv    = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int base;
    int n0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", updEn, 0);
    chk("rst_pc", updPC, 0);
    reset = 1'b0;
    chk("rst_ready", cmtReady, 1);

    // four commit pushes drain in cycles 3..6
    base = cyc;
    for (int i = 0; i < 4; i++) expect_upd(32'h100 + 32'(4 * i), base + 2 + i);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 0, 1'b0);
    idle(4);
    chk("a_drained", expq.size(), 0);

    // FS2 re-offered every cycle: C,C,C,F pattern until FIFO fills
    do_reset();
    base = cyc;
    for (int i = 0; i < 17; i++) expect_upd(pcsB[i], base + 2 + i);
    for (int k = 0; k < 13; k++) begin
      if (k == 12) chk("b_ready_3", cmtReady, 1);
      drive(1'b1, 32'h400 + 32'(4 * k), 1'b1, 32'h800 + 32'(4 * k), 1'b0);
    end
    chk("b_full_ready", cmtReady, 0);
    drive(1'b1, 32'h434, 1'b0, 0, 1'b0);
    idle(8);
    chk("b_drained", expq.size(), 0);
`ifdef BP_UPD_STATS_EN
    chk("b_stat_drop", statDrop, 9);
    chk("b_stat_starve", statStv, 4);
`endif

    // FS2 0x200 overwritten by 0x204 while commit busy
    do_reset();
    base = cyc;
    expect_upd(32'h500, base + 2);
    expect_upd(32'h504, base + 3);
    expect_upd(32'h508, base + 4);
    expect_upd(32'h204, base + 5);
    drive(1'b1, 32'h500, 1'b0, 0, 1'b0);
    drive(1'b1, 32'h504, 1'b1, 32'h200, 1'b0);
    drive(1'b1, 32'h508, 1'b1, 32'h204, 1'b0);
    idle(6);
    chk("c_drained", expq.size(), 0);
`ifdef BP_UPD_STATS_EN
    chk("c_stat_drop", statDrop, 1);
    chk("c_stat_starve", statStv, 0);
`endif

    // flush beats a same-cycle FS2 load
    do_reset();
    n0 = nUpd;
    drive(1'b0, 0, 1'b1, 32'h300, 1'b1);
    idle(5);
    chk("d_flush_quiet", nUpd - n0, 0);
    base = cyc;
    expect_upd(32'h304, base + 2);
    drive(1'b0, 0, 1'b1, 32'h304, 1'b0);
    idle(4);
    chk("d_drained", expq.size(), 0);

    // reset mid-drain with three commit entries queued
    do_reset();
    base = cyc;
    for (int i = 0; i < 7; i++) expect_upd(pcsB[i], base + 2 + i);
    for (int k = 0; k < 9; k++)
      drive(1'b1, 32'h400 + 32'(4 * k), 1'b1, 32'h800 + 32'(4 * k), 1'b0);
    reset = 1'b1;
    cv    = 1'b0;
    fv    = 1'b0;
    #1;
    chk("e_rst_en", updEn, 0);
    chk("e_rst_pc", updPC, 0);
    chk("e_rst_fields", {updNPC, updType, updDir, updCnt}, 0);
    chk("e_drained", expq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("e_ready", cmtReady, 1);
    n0 = nUpd;
    idle(10);
    chk("e_no_replay", nUpd - n0, 0);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule

// File: doc/bp_update_arbiter.md
BP_UPDATE_ARBITER -- requirements
Module: bp_update_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, commit-update FIFO entries (power of 2, at least 2).
REQ-002 SHALL have parameter STARVE_MAX, default 3, consecutive commit grants allowed while an FS2 update waits.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, as the following port lines state.
- clk  input  1  sole clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush_i  input  1  front-end flush; discards the pending FS2 update.
- cmtValid_i  input  1  commit-side resolved control-flow update offered.
- cmtReady_o  output  1  commit FIFO can accept this cycle.
- cmtPkt_i  input  bpUpdPkt  PC, NPC, ctrlType, dir, counter from commit.
- fs2Valid_i  input  1  FS2 decode-detected update (BTB miss/mismatch) offered.
- fs2Pkt_i  input  bpUpdPkt  same fields from FS2.
- updatePC_o  output  `SIZE_PC  granted update PC.
- updateNPC_o  output  `SIZE_PC  granted update target.
- updateCtrlType_o  output  `BRANCH_TYPE  granted control type.
- updateDir_o  output  1  granted direction.
- updateCounter_o  output  2  granted 2-bit counter value.
- updateEn_o  output  1  update valid this cycle.

Function
REQ-004 SHALL push cmtPkt_i when cmtValid_i and cmtReady_o are both high at a clock edge.
REQ-005 SHALL drive cmtReady_o = (count < DEPTH) from registered count only; a full FIFO refuses a push even in a pop cycle.
REQ-006 SHALL use read/write pointers that wrap modulo DEPTH and preserve FIFO order.
REQ-007 SHALL hold one FS2 entry; fs2Valid_i with flush_i low loads it (pending=1), overwriting any older unsent entry.
REQ-008 SHALL give flush_i priority over a same-cycle FS2 load; pending clears and nothing loads; FIFO unaffected.
REQ-009 SHALL, when an FS2 entry is granted in the same cycle a new fs2Valid_i arrives, send the old entry and retain the new one as pending.
REQ-010 SHALL arbitrate combinationally each cycle: FIFO empty and pending -> FS2; FIFO non-empty and not pending -> commit; both -> FS2 iff starveCnt == STARVE_MAX, else commit.
REQ-011 SHALL increment starveCnt, saturating at STARVE_MAX, on each commit grant while pending, and clear it on an FS2 grant or whenever pending is 0.
REQ-012 SHALL register the granted packet onto update*_o with updateEn_o=1 one edge after the grant; a request offered in cycle n appears in cycle n+2 at earliest.
REQ-013 SHALL, in cycles with no grant, drive updateEn_o=0 and hold update data outputs at their previous values.

Reset
REQ-014 SHALL, on reset assertion, asynchronously zero all outputs, FIFO pointers/count, pending, starveCnt and stats; cmtReady_o=1 once reset deasserts.
REQ-015 SHALL discard in-flight FIFO entries and the FS2 entry if reset occurs mid-operation; nothing is replayed.

Configuration
REQ-016 SHALL, with BP_UPD_STATS_EN defined, add outputs statFs2Drop_o (32b, count of FS2 overwrites per REQ-007) and statStarveGrant_o (32b, FS2 grants forced by starveCnt==STARVE_MAX), both wrapping and zeroed by reset.
REQ-017 SHALL, without BP_UPD_STATS_EN, omit both ports and counters with no other behavioural change.

Structure
REQ-018 SHALL take typedef bpUpdPkt and the BP_UPD_SRC_CMT/BP_UPD_SRC_FS2 source encoding from the shared core package.
REQ-019 SHALL implement the commit queue as sub-module bp_upd_fifo, parameterised by DEPTH.

Verification
REQ-020 SHALL cover: 4 commit pushes PC 0x100,0x104,0x108,0x10C from cycle 1, no FS2 -> updateEn_o cycles 3-6 in order; 5th push while full sees cmtReady_o=0.
REQ-021 SHALL cover: FS2 pending, FIFO kept non-empty, STARVE_MAX=3 -> grant sequence C,C,C,F repeating.
REQ-022 SHALL cover: FS2 0x200 then 0x204 next cycle while FIFO busy -> only 0x204 emitted; statFs2Drop_o=1 with BP_UPD_STATS_EN.
REQ-023 SHALL cover: flush_i and fs2Valid_i (0x300) same cycle, FIFO empty -> updateEn_o stays 0.
REQ-024 SHALL cover: reset asserted mid-drain with 3 entries queued -> outputs 0 immediately; after release no stale update issues and cmtReady_o=1.
